// File: rtl/branch_predictor_if.sv
// Fetch/resolve-side bundle for the branch direction predictor.
// The master side is the core (fetch + branch resolve); the slave side is the predictor.
interface branch_predictor_if #(
    parameter int STAT_BITS = 32
);
    logic [31:0]          pred_pc;
    logic                 pred_taken;
    logic                 res_valid;
    logic                 res_branch;
    logic [31:0]          res_pc;
    logic                 res_cnd;
    logic                 res_pred;
    logic                 mispredict;
    logic [STAT_BITS-1:0] br_count;
    logic [STAT_BITS-1:0] mp_count;

    modport master (
        output pred_pc, res_valid, res_branch, res_pc, res_cnd, res_pred,
        input  pred_taken, mispredict, br_count, mp_count
    );

    modport slave (
        input  pred_pc, res_valid, res_branch, res_pc, res_cnd, res_pred,
        output pred_taken, mispredict, br_count, mp_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Table of 2-bit saturating direction counters with saturating branch/mispredict statistics.
// Optional gshare indexing (global history XOR PC bits) with BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
    parameter int IDX_BITS  = 6,
    parameter int STAT_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_BITS;

    typedef logic [1:0]           ctr_t;
    typedef logic [STAT_BITS-1:0] stat_t;
    typedef logic [IDX_BITS-1:0]  idx_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'd1;
        else       return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    function automatic stat_t sat_inc(input stat_t v);
        return (&v) ? v : v + stat_t'(1);
    endfunction

    ctr_t  tbl [ENTRIES];
    idx_t  pred_idx;
    idx_t  upd_idx;
    logic  upd;
    logic  mp_cond;
    logic  mp_p1;
    stat_t br_cnt_p1;
    stat_t mp_cnt_p1;

    assign upd     = bp.res_valid && bp.res_branch;
    assign mp_cond = upd && (bp.res_cnd != bp.res_pred);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    idx_t ghr;

    // History used for both indices is the value before this cycle's shift.
    assign pred_idx = bp.pred_pc[IDX_BITS+1:2] ^ ghr;
    assign upd_idx  = bp.res_pc[IDX_BITS+1:2] ^ ghr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (upd) begin
            ghr <= {ghr[IDX_BITS-2:0], bp.res_cnd};
        end
    end
`else
    assign pred_idx = bp.pred_pc[IDX_BITS+1:2];
    assign upd_idx  = bp.res_pc[IDX_BITS+1:2];
`endif

    // Read is the pre-update table value; a same-cycle write to the same entry is not bypassed.
    assign bp.pred_taken = tbl[pred_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i] <= 2'b01;
            end
        end else if (upd) begin
            tbl[upd_idx] <= ctr_next(tbl[upd_idx], bp.res_cnd);
        end
    end

    // Stage p1: registered mispredict pulse and statistics, one cycle after resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mp_p1     <= 1'b0;
            br_cnt_p1 <= '0;
            mp_cnt_p1 <= '0;
        end else begin
            mp_p1 <= mp_cond;
            if (upd) begin
                br_cnt_p1 <= sat_inc(br_cnt_p1);
            end
            if (mp_cond) begin
                mp_cnt_p1 <= sat_inc(mp_cnt_p1);
            end
        end
    end

    assign bp.mispredict = mp_p1;
    assign bp.br_count   = br_cnt_p1;
    assign bp.mp_count   = mp_cnt_p1;
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor; two instances (32-bit and 4-bit stats) share stimulus.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    bit   run_chk = 1'b0;

    always #5 clk = ~clk;

    branch_predictor_if #(.STAT_BITS(32)) ifa ();
    branch_predictor_if #(.STAT_BITS(4))  ifb ();

    assign ifb.pred_pc    = ifa.pred_pc;
    assign ifb.res_valid  = ifa.res_valid;
    assign ifb.res_branch = ifa.res_branch;
    assign ifb.res_pc     = ifa.res_pc;
    assign ifb.res_cnd    = ifa.res_cnd;
    assign ifb.res_pred   = ifa.res_pred;

    branch_predictor #(.IDX_BITS(6), .STAT_BITS(32)) dut_a (.clk(clk), .rst_n(rst_n), .bp(ifa));
    branch_predictor #(.IDX_BITS(6), .STAT_BITS(4))  dut_b (.clk(clk), .rst_n(rst_n), .bp(ifb));

    // Behavioural model: counter values as integers 0..3, unbounded event counts clipped on compare.
    int unsigned     mtbl [64];
    longint unsigned br_n;
    longint unsigned mp_n;
    bit              mp_m;
    int unsigned     ghr_m;

    function automatic int unsigned midx(input logic [31:0] pc);
        return ((pc >> 2) & 32'd63) ^ ghr_m;
    endfunction

    function automatic bit mpred(input logic [31:0] pc);
        return mtbl[midx(pc)] >= 2;
    endfunction

    function automatic longint unsigned clip(input longint unsigned n, input longint unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic void model_reset();
        foreach (mtbl[i]) mtbl[i] = 1;
        br_n  = 0;
        mp_n  = 0;
        mp_m  = 1'b0;
        ghr_m = 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int unsigned k;
        bit u;
        if (!rst_n) begin
            model_reset();
        end else begin
            u    = ifa.res_valid && ifa.res_branch;
            k    = midx(ifa.res_pc);
            mp_m = u && (ifa.res_cnd != ifa.res_pred);
            if (u) begin
                if (ifa.res_cnd && mtbl[k] < 3) mtbl[k] = mtbl[k] + 1;
                else if (!ifa.res_cnd && mtbl[k] > 0) mtbl[k] = mtbl[k] - 1;
                br_n++;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
                ghr_m = ((ghr_m << 1) | int'(ifa.res_cnd)) & 32'd63;
`endif
            end
            if (mp_m) mp_n++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && run_chk) begin
            chk("pred_taken_a", 64'(ifa.pred_taken), 64'(mpred(ifa.pred_pc)));
            chk("pred_taken_b", 64'(ifb.pred_taken), 64'(mpred(ifa.pred_pc)));
            chk("mispredict_a", 64'(ifa.mispredict), 64'(mp_m));
            chk("mispredict_b", 64'(ifb.mispredict), 64'(mp_m));
            chk("br_count_a", 64'(ifa.br_count), clip(br_n, 64'hFFFF_FFFF));
            chk("mp_count_a", 64'(ifa.mp_count), clip(mp_n, 64'hFFFF_FFFF));
            chk("br_count_b", 64'(ifb.br_count), clip(br_n, 64'd15));
            chk("mp_count_b", 64'(ifb.mp_count), clip(mp_n, 64'd15));
        end
    end

    task automatic apply(input logic [31:0] ppc, input logic v, input logic b,
                         input logic [31:0] rpc, input logic c, input logic p);
        @(negedge clk);
        #1;
        ifa.pred_pc    = ppc;
        ifa.res_valid  = v;
        ifa.res_branch = b;
        ifa.res_pc     = rpc;
        ifa.res_cnd    = c;
        ifa.res_pred   = p;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        logic        c;
        model_reset();
        rst_n          = 1'b0;
        ifa.pred_pc    = 32'h100;
        ifa.res_valid  = 1'b0;
        ifa.res_branch = 1'b0;
        ifa.res_pc     = 32'h0;
        ifa.res_cnd    = 1'b0;
        ifa.res_pred   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n   = 1'b1;
        run_chk = 1'b1;
        #1;
        chk("rst_pred", 64'(ifa.pred_taken), 64'd0);
        chk("rst_br", 64'(ifa.br_count), 64'd0);
        chk("rst_mp", 64'(ifa.mp_count), 64'd0);
        chk("rst_mispredict", 64'(ifa.mispredict), 64'd0);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
        // Train 0x100 up to strongly taken, saturating at 11.
        for (int i = 1; i <= 3; i++) begin
            apply(32'h100, 1, 1, 32'h100, 1, 0);
            after_edge();
            chk("up_pred", 64'(ifa.pred_taken), 64'd1);
            chk("up_mispredict", 64'(ifa.mispredict), 64'd1);
            chk("up_br", 64'(ifa.br_count), 64'(i));
            chk("up_mp", 64'(ifa.mp_count), 64'(i));
        end
        apply(32'h100, 1, 1, 32'h100, 0, 1);
        after_edge();
        chk("hyst_pred_10", 64'(ifa.pred_taken), 64'd1);
        apply(32'h100, 1, 1, 32'h100, 0, 1);
        after_edge();
        chk("hyst_pred_01", 64'(ifa.pred_taken), 64'd0);
        chk("hyst_br", 64'(ifa.br_count), 64'd5);
        chk("hyst_mp", 64'(ifa.mp_count), 64'd5);

        apply(32'h200, 1, 0, 32'h200, 1, 0);
        after_edge();
        chk("nonbr_pred", 64'(ifa.pred_taken), 64'd0);
        chk("nonbr_br", 64'(ifa.br_count), 64'd5);
        chk("nonbr_mispredict", 64'(ifa.mispredict), 64'd0);

        apply(32'h104, 1, 1, 32'h104, 1, 0);
        #1;
        chk("coll_pred_same", 64'(ifa.pred_taken), 64'd0);
        after_edge();
        chk("coll_pred_next", 64'(ifa.pred_taken), 64'd1);
        chk("coll_mispredict", 64'(ifa.mispredict), 64'd1);

        // Reset lands in the middle of a pending update to 0x100.
        apply(32'h100, 1, 1, 32'h100, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_mispredict", 64'(ifa.mispredict), 64'd0);
        chk("mrst_br", 64'(ifa.br_count), 64'd0);
        chk("mrst_mp", 64'(ifa.mp_count), 64'd0);
        ifa.pred_pc = 32'h104;
        #1;
        chk("mrst_pred_104", 64'(ifa.pred_taken), 64'd0);
        ifa.res_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        ifa.pred_pc = 32'h100;
        #1;
        chk("mrst_pred_100", 64'(ifa.pred_taken), 64'd0);
        chk("mrst_br_after", 64'(ifa.br_count), 64'd0);
`endif

        // Statistics saturation on the 4-bit instance.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pc = 32'($urandom_range(0, 63)) << 2;
            c  = 1'($urandom_range(0, 1));
            apply(pc, 1, 1, pc, c, ~c);
        end
        after_edge();
        chk("sat_br_b", 64'(ifb.br_count), 64'd15);
        chk("sat_mp_b", 64'(ifb.mp_count), 64'd15);
        chk("sat_br_a", 64'(ifa.br_count), 64'd20);
        chk("sat_mp_a", 64'(ifa.mp_count), 64'd20);

        // Random traffic over a small PC pool to provoke aliasing, collisions and saturation.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            pc = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 8)
               | 32'($urandom_range(0, 3));
            if (i < 1500) c = ($urandom_range(0, 3) != 0);
            else          c = ($urandom_range(0, 3) == 0);
            ifa.res_pc     = pc;
            ifa.pred_pc    = ($urandom_range(0, 2) == 0) ? pc
                           : (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 12);
            ifa.res_valid  = ($urandom_range(0, 4) != 0);
            ifa.res_branch = ($urandom_range(0, 5) != 0);
            ifa.res_cnd    = c;
            ifa.res_pred   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
